btb_update_ctrl: RTL and testbench
==================================

Name: btb_update_ctrl

Overview:
Sequences all writes into the 4-entry branch target buffer for the pipelined MIPS core. It takes resolved branches from the EX/MEM boundary, detects mispredictions, and raises a registered flush/redirect to fetch. Resolved branches are queued in a small FIFO and drained into the BTB write port (WEN, pc_w, target_w, taken_w) when the core permits. It also runs the invalidate sweep after reset or on request.

Parameters:
DEPTH, 2, update FIFO entries; power of 2, ≥2
ENTRIES, 4, BTB entries swept during clear; matches btb_entry_t [3:0]

Ports:
CLK  in  1  system clock, rising edge
nRST  in  1  asynchronous active-low reset
resolve_valid  in  1  resolved branch/jump this cycle (one-cycle pulse per branch)
resolve_pc  in  32  PC of resolved branch
resolve_target  in  32  computed target
resolve_taken  in  1  actual outcome
pred_taken  in  1  prediction carried down the pipe with this branch
pred_target  in  32  predicted target carried down the pipe
wr_allow  in  1  BTB write port may be used this cycle
clear_req  in  1  request full BTB invalidate (pulse)
halt  in  1  core halted; freeze controller
flush  out  1  squash IF/ID/EX; one-cycle pulse
redirect_pc  out  32  fetch PC valid while flush=1
btb_wen  out  1  BTB WEN
btb_pc_w  out  32  BTB pc_w
btb_target_w  out  32  BTB target_w
btb_taken_w  out  1  BTB taken_w
btb_clr  out  1  invalidate entry btb_clr_idx
btb_clr_idx  out  $clog2(ENTRIES)  entry being cleared
busy  out  1  state is CLEAR
drop_cnt  out  8  updates dropped on full FIFO; saturates at 255

Behaviour:
- Reset: every output 0, FIFO empty, state CLEAR, clr index 0.
- States: CLEAR, RUN, HALT.
- CLEAR: btb_clr=1, btb_clr_idx = index. Index increments each cycle. After index ENTRIES-1 (4 cycles total), go to RUN. btb_wen=0 throughout. resolve_valid in CLEAR is ignored for the FIFO, but flush still operates.
- RUN: halt=1 → HALT next cycle. clear_req=1 → empty the FIFO and go to CLEAR next cycle (clear_req wins over halt).
- HALT: no writes, FIFO contents held, flush suppressed. Leaves only via reset.
- Mispredict condition: resolve_valid and either (resolve_taken ≠ pred_taken) or (resolve_taken and resolve_target ≠ pred_target).
- Flush: on a mispredict, flush=1 in the next cycle for exactly one cycle.
  - redirect_pc = resolve_target if taken, else resolve_pc + 4 (32-bit wrap).
  - Back-to-back mispredicts in consecutive cycles each produce a flush; the later branch's redirect is used.
- Enqueue: every resolve_valid in RUN pushes {pc, target, taken}, whether or not it mispredicted.
- Dequeue: when state=RUN, FIFO non-empty and wr_allow=1, drive btb_wen=1 combinationally with the head entry and pop at the clock edge. One write per cycle maximum.
- A branch enqueued into an empty FIFO can be written no earlier than the next cycle (no bypass).
- FIFO full plus push without a pop in the same cycle: the new entry is dropped and drop_cnt increments.
- Full plus simultaneous push and pop: both occur and no drop.
- Pointers wrap modulo DEPTH; an extra pointer bit distinguishes full from empty.
- btb_wen and btb_clr are never high in the same cycle.
- Async reset mid-CLEAR or mid-drain: immediate return to reset values; the sweep restarts from index 0.

Optional Feature:
- Macro: BTB_STATS_EN.
- Defined: adds 32-bit outputs branch_cnt (increments on each resolve_valid outside HALT) and mispred_cnt (increments on each mispredict outside HALT). Both wrap and reset to 0.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Test Plan:
1. Release nRST → btb_clr=1 for 4 cycles with idx 0,1,2,3; busy=1 during the sweep, then 0; no btb_wen.
2. RUN, wr_allow=1, resolve pc=0x40, target=0x80, taken=1, pred_taken=0 → next cycle: flush=1, redirect_pc=0x80, btb_wen=1 with pc_w=0x40, target_w=0x80, taken_w=1.
3. resolve pc=0x100, taken=0, pred_taken=1 → flush=1, redirect_pc=0x104. Correct prediction (taken both, targets equal) → flush stays 0, but the BTB write still occurs.
4. wr_allow=0, three resolves 0x10/0x20/0x30 with DEPTH=2 → drop_cnt=1. Then wr_allow=1 → writes 0x10 then 0x20 in consecutive cycles, then btb_wen=0.
5. Two entries queued, clear_req=1 → FIFO emptied, 4-cycle sweep, no btb_wen for the queued entries. halt=1 in RUN → no further flush or btb_wen.
6. Assert nRST low during sweep idx 2 → all outputs 0 immediately; on release the sweep restarts at idx 0.

Source files
------------

// File: rtl/btb_update_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : btb_update_ctrl
// Description : Sequences BTB writes: mispredict flush/redirect, update FIFO
//               drain, and post-reset/requested invalidate sweep.
//               Optional macro BTB_STATS_EN adds branch/mispredict counters.
// Revision    : 1.0 - initial release
// ============================================================================
module btb_update_ctrl #(
    parameter int DEPTH   = 2,
    parameter int ENTRIES = 4
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic                       resolve_valid,
    input  logic [31:0]                resolve_pc,
    input  logic [31:0]                resolve_target,
    input  logic                       resolve_taken,
    input  logic                       pred_taken,
    input  logic [31:0]                pred_target,
    input  logic                       wr_allow,
    input  logic                       clear_req,
    input  logic                       halt,
    output logic                       flush,
    output logic [31:0]                redirect_pc,
    output logic                       btb_wen,
    output logic [31:0]                btb_pc_w,
    output logic [31:0]                btb_target_w,
    output logic                       btb_taken_w,
    output logic                       btb_clr,
    output logic [$clog2(ENTRIES)-1:0] btb_clr_idx,
    output logic                       busy,
    output logic [7:0]                 drop_cnt
`ifdef BTB_STATS_EN
    ,
    output logic [31:0]                branch_cnt,
    output logic [31:0]                mispred_cnt
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int IW = $clog2(ENTRIES);
    localparam logic [IW-1:0] C_LAST_IDX = IW'(ENTRIES - 1);
    localparam logic [IW-1:0] C_IDX_ONE  = IW'(1);
    localparam logic [AW:0]   C_PTR_ONE  = (AW + 1)'(1);

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_RUN   = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [IW-1:0]   r_clr_idx;
    logic [31:0]     r_fifo_pc  [DEPTH];
    logic [31:0]     r_fifo_tgt [DEPTH];
    logic            r_fifo_tk  [DEPTH];
    logic [AW:0]     r_wr_ptr;
    logic [AW:0]     r_rd_ptr;
    logic            r_flush;
    logic [31:0]     r_redirect;
    logic [7:0]      r_drop_cnt;

    logic w_empty, w_full, w_mispredict, w_push, w_pop, w_drop, w_run;

    assign w_run        = (r_state == S_RUN);
    assign w_empty      = (r_wr_ptr == r_rd_ptr);
    assign w_full       = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                          (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_mispredict = resolve_valid &&
                          ((resolve_taken != pred_taken) ||
                           (resolve_taken && (resolve_target != pred_target)));
    assign w_pop        = w_run && !w_empty && wr_allow;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push       = w_run && resolve_valid && (!w_full || w_pop);
    assign w_drop       = w_run && resolve_valid && w_full && !w_pop;

    always_comb begin
        w_next       = r_state;
        btb_wen      = 1'b0;
        btb_pc_w     = 32'd0;
        btb_target_w = 32'd0;
        btb_taken_w  = 1'b0;
        case (r_state)
            S_CLEAR: if (r_clr_idx == C_LAST_IDX) w_next = S_RUN;
            S_RUN: begin
                if (clear_req)  w_next = S_CLEAR;
                else if (halt)  w_next = S_HALT;
                if (w_pop) begin
                    btb_wen      = 1'b1;
                    btb_pc_w     = r_fifo_pc[r_rd_ptr[AW-1:0]];
                    btb_target_w = r_fifo_tgt[r_rd_ptr[AW-1:0]];
                    btb_taken_w  = r_fifo_tk[r_rd_ptr[AW-1:0]];
                end
            end
            S_HALT:  w_next = S_HALT;
            default: w_next = S_CLEAR;
        endcase
    end

    // Sweep indicators are gated by nRST so every output reads 0 while reset is held.
    assign btb_clr     = (r_state == S_CLEAR) && nRST;
    assign busy        = (r_state == S_CLEAR) && nRST;
    assign btb_clr_idx = r_clr_idx;
    assign flush       = r_flush;
    assign redirect_pc = r_redirect;
    assign drop_cnt    = r_drop_cnt;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state    <= S_CLEAR;
            r_clr_idx  <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_flush    <= 1'b0;
            r_redirect <= 32'd0;
            r_drop_cnt <= 8'd0;
        end else begin
            r_state <= w_next;
            if (r_state == S_CLEAR)
                r_clr_idx <= (r_clr_idx == C_LAST_IDX) ? '0 : r_clr_idx + C_IDX_ONE;
            else
                r_clr_idx <= '0;

            r_flush <= w_mispredict && (r_state != S_HALT);
            if (w_mispredict && (r_state != S_HALT))
                r_redirect <= resolve_taken ? resolve_target : resolve_pc + 32'd4;

            if (w_run && clear_req) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end

            if (w_drop && (r_drop_cnt != 8'hFF))
                r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    // Payload storage needs no reset: reads are qualified by the pointers.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_fifo_pc[r_wr_ptr[AW-1:0]]  <= resolve_pc;
            r_fifo_tgt[r_wr_ptr[AW-1:0]] <= resolve_target;
            r_fifo_tk[r_wr_ptr[AW-1:0]]  <= resolve_taken;
        end
    end

`ifdef BTB_STATS_EN
    logic [31:0] r_branch_cnt;
    logic [31:0] r_mispred_cnt;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_branch_cnt  <= 32'd0;
            r_mispred_cnt <= 32'd0;
        end else if (r_state != S_HALT) begin
            if (resolve_valid) r_branch_cnt  <= r_branch_cnt + 32'd1;
            if (w_mispredict)  r_mispred_cnt <= r_mispred_cnt + 32'd1;
        end
    end

    assign branch_cnt  = r_branch_cnt;
    assign mispred_cnt = r_mispred_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_btb_update_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_btb_update_ctrl
// Description : Directed + randomized bench for btb_update_ctrl against a
//               queue-based behavioural model (BTB_STATS_EN counters if defined).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_btb_update_ctrl;

    localparam int DEPTH   = 2;
    localparam int ENTRIES = 4;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        resolve_valid = 1'b0;
    logic [31:0] resolve_pc = '0, resolve_target = '0, pred_target = '0;
    logic        resolve_taken = 1'b0, pred_taken = 1'b0;
    logic        wr_allow = 1'b0, clear_req = 1'b0, halt = 1'b0;
    logic        flush, btb_wen, btb_taken_w, btb_clr, busy;
    logic [31:0] redirect_pc, btb_pc_w, btb_target_w;
    logic [1:0]  btb_clr_idx;
    logic [7:0]  drop_cnt;
`ifdef BTB_STATS_EN
    logic [31:0] branch_cnt, mispred_cnt;
`endif

    btb_update_ctrl #(.DEPTH(DEPTH), .ENTRIES(ENTRIES)) dut (
        .CLK(CLK), .nRST(nRST),
        .resolve_valid(resolve_valid), .resolve_pc(resolve_pc),
        .resolve_target(resolve_target), .resolve_taken(resolve_taken),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .wr_allow(wr_allow), .clear_req(clear_req), .halt(halt),
        .flush(flush), .redirect_pc(redirect_pc),
        .btb_wen(btb_wen), .btb_pc_w(btb_pc_w), .btb_target_w(btb_target_w),
        .btb_taken_w(btb_taken_w), .btb_clr(btb_clr), .btb_clr_idx(btb_clr_idx),
        .busy(busy), .drop_cnt(drop_cnt)
`ifdef BTB_STATS_EN
        , .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Behavioural model: mode 0 = sweeping, 1 = running, 2 = halted.
    typedef struct { logic [31:0] pc; logic [31:0] tgt; logic tk; } ent_t;
    ent_t        q[$];
    int          m_mode, m_idx, m_drop;
    logic        m_flush;
    logic [31:0] m_redir, m_br, m_mp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_mode = 0; m_idx = 0; m_drop = 0;
        m_flush = 1'b0; m_redir = '0; m_br = '0; m_mp = '0;
    endtask

    function automatic logic exp_wen();
        return (m_mode == 1) && (q.size() > 0) && wr_allow;
    endfunction

    task automatic sample();
        logic w;
        @(negedge CLK);
        w = exp_wen();
        chk("flush", flush, m_flush);
        if (m_flush) chk("redirect_pc", redirect_pc, m_redir);
        chk("btb_wen", btb_wen, w);
        if (w) begin
            chk("btb_pc_w", btb_pc_w, q[0].pc);
            chk("btb_target_w", btb_target_w, q[0].tgt);
            chk("btb_taken_w", btb_taken_w, q[0].tk);
        end
        chk("btb_clr", btb_clr, m_mode == 0);
        chk("busy", busy, m_mode == 0);
        if (m_mode == 0) chk("btb_clr_idx", btb_clr_idx, m_idx);
        chk("drop_cnt", drop_cnt, m_drop);
        chk("wen_clr_excl", btb_wen & btb_clr, 0);
`ifdef BTB_STATS_EN
        chk("branch_cnt", branch_cnt, m_br);
        chk("mispred_cnt", mispred_cnt, m_mp);
`endif
    endtask

    task automatic advance();
        logic mis;
        @(posedge CLK);
        mis = resolve_valid && ((resolve_taken != pred_taken) ||
              (resolve_taken && (resolve_target != pred_target)));
        if (m_mode != 2) begin
            if (resolve_valid) m_br++;
            if (mis) m_mp++;
        end
        m_flush = mis && (m_mode != 2);
        if (m_flush) m_redir = resolve_taken ? resolve_target : resolve_pc + 32'd4;
        if (m_mode == 1) begin
            if (exp_wen()) void'(q.pop_front());
            if (resolve_valid) begin
                if (q.size() < DEPTH) q.push_back('{resolve_pc, resolve_target, resolve_taken});
                else if (m_drop < 255) m_drop++;
            end
            if (clear_req) begin q.delete(); m_mode = 0; m_idx = 0; end
            else if (halt) m_mode = 2;
        end else if (m_mode == 0) begin
            if (m_idx == ENTRIES - 1) m_mode = 1;
            else m_idx++;
        end
        #1;
    endtask

    task automatic step(); sample(); advance(); endtask

    task automatic idle();
        resolve_valid = 0; resolve_pc = '0; resolve_target = '0; resolve_taken = 0;
        pred_taken = 0; pred_target = '0; clear_req = 0; halt = 0;
    endtask

    task automatic resolve(input logic [31:0] pc, input logic [31:0] tgt, input logic tk,
                           input logic ptk, input logic [31:0] ptgt);
        resolve_valid = 1; resolve_pc = pc; resolve_target = tgt; resolve_taken = tk;
        pred_taken = ptk; pred_target = ptgt;
    endtask

    task automatic check_reset_zero(input string tag);
        chk({tag, "_flush"}, flush, 0);
        chk({tag, "_redirect"}, redirect_pc, 0);
        chk({tag, "_wen"}, btb_wen, 0);
        chk({tag, "_pc_w"}, btb_pc_w, 0);
        chk({tag, "_clr"}, btb_clr, 0);
        chk({tag, "_clr_idx"}, btb_clr_idx, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_drop"}, drop_cnt, 0);
    endtask

    task automatic do_reset(input string tag);
        nRST = 0;
        #1;
        check_reset_zero(tag);
        model_reset();
        @(posedge CLK); @(posedge CLK); #1;
        nRST = 1;
    endtask

    initial begin
        model_reset();
        idle();
        do_reset("rst0");

        // Sweep after reset: idx 0..3 with busy, then RUN.
        for (int i = 0; i < ENTRIES; i++) begin
            sample(); chk("sweep_idx", btb_clr_idx, i); advance();
        end
        sample(); chk("sweep_done_busy", busy, 0); advance();

        // Taken mispredict written and redirected.
        wr_allow = 1;
        resolve(32'h40, 32'h80, 1, 0, 32'h0); step(); idle();
        sample(); chk("t2_flush", flush, 1); chk("t2_redir", redirect_pc, 32'h80);
        chk("t2_wen_pc", btb_pc_w, 32'h40); advance();
        sample(); chk("t2_flush_pulse", flush, 0); advance();

        // Not-taken mispredict, then a correct prediction.
        resolve(32'h100, 32'h500, 0, 1, 32'h500); step(); idle();
        sample(); chk("t3_redir", redirect_pc, 32'h104); advance();
        resolve(32'h200, 32'h300, 1, 1, 32'h300); step(); idle();
        sample(); chk("t3_noflush", flush, 0); chk("t3_wen_pc", btb_pc_w, 32'h200); advance();

        // Overflow with writes blocked.
        wr_allow = 0;
        resolve(32'h10, 32'h0, 0, 0, 32'h0); step();
        resolve(32'h20, 32'h0, 0, 0, 32'h0); step();
        resolve(32'h30, 32'h0, 0, 0, 32'h0); step(); idle();
        wr_allow = 1;
        sample(); chk("t4_drop", drop_cnt, 1); chk("t4_w0", btb_pc_w, 32'h10); advance();
        sample(); chk("t4_w1", btb_pc_w, 32'h20); advance();
        sample(); chk("t4_empty", btb_wen, 0); advance();

        // Clear request discards queued entries.
        wr_allow = 0;
        resolve(32'h44, 32'h0, 0, 0, 32'h0); step();
        resolve(32'h48, 32'h0, 0, 0, 32'h0); step(); idle();
        clear_req = 1; step(); clear_req = 0; wr_allow = 1;
        for (int i = 0; i < ENTRIES + 2; i++) step();
        sample(); chk("t5_no_stale_wen", btb_wen, 0); advance();

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            resolve_valid  = ($urandom_range(0, 2) != 0);
            resolve_pc     = $urandom & 32'hFFFF_FFFC;
            resolve_target = $urandom & 32'hFFFF_FFFC;
            resolve_taken  = $urandom_range(0, 1);
            pred_taken     = $urandom_range(0, 3) != 0 ? resolve_taken : ~resolve_taken;
            pred_target    = $urandom_range(0, 3) != 0 ? resolve_target : $urandom;
            if ($urandom_range(0, 20) == 0) resolve_pc = 32'hFFFF_FFFC;
            wr_allow       = ($urandom_range(0, 3) != 0);
            clear_req      = ($urandom_range(0, 60) == 0);
            step();
        end
        idle();

        // Halt freezes the controller.
        for (int n = 0; n < 10 && m_mode != 1; n++) step();
        chk("halt_in_run", m_mode, 1);
        halt = 1; step(); halt = 0;
        for (int n = 0; n < 12; n++) begin
            resolve(32'h600 + n * 4, 32'h900, 1, 0, 32'h0);
            wr_allow = 1;
            step();
        end
        idle();
        sample(); chk("halt_noflush", flush, 0); chk("halt_nowen", btb_wen, 0); advance();

        // Reset in the middle of the sweep restarts from index 0.
        do_reset("rst1");
        for (int n = 0; n < 10 && !(m_mode == 0 && m_idx == 2); n++) step();
        chk("at_idx2", btb_clr_idx, 2);
        do_reset("rst_mid");
        sample(); chk("restart_idx", btb_clr_idx, 0); chk("restart_busy", busy, 1); advance();
        for (int n = 0; n < 6; n++) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
